multicore_core_image_loader: RTL and testbench

Streams a program image from a byte-wide host channel into one core's dual-port on-chip memory through that memory's second (s2) port, while holding the core in reset. It sits directly upstream of the per-core program RAM in the multicore system. It parses a 4-byte header, packs payload bytes little-endian into 32-bit words with byte enables, and optionally checks a trailing checksum. The core is released only after a clean load.

---
 rtl/multicore_core_image_loader.sv | 230 +++++++++++++++++++++++
 tb/tb_multicore_core_image_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicore_core_image_loader.sv
// Program-image loader: parses a 4-byte header and packs payload bytes into RAM port-2 writes while the core is held in reset.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CSUM_EN.
module multicore_core_image_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              rearm,
  output logic [ADDR_W-1:0] address2,
  output logic [3:0]        byteenable2,
  output logic              chipselect2,
  output logic              write2,
  output logic [31:0]       writedata2,
  output logic              clken2,
  output logic              core_reset_req,
  output logic              done,
  output logic              error
);

  // state  | meaning
  // S_IDLE | waiting for header byte 0
  // S_HDR  | collecting header bytes 1..3
  // S_DATA | packing payload bytes into words
  // S_CSUM | waiting for the checksum byte
  // S_DONE | clean load, core released
  // S_ERR  | failed load, input drained
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

  state_t            r_state;
  logic              r_live;
  logic [1:0]        r_hdr_idx;
  logic [15:0]       r_len;
  logic [7:0]        r_base_lo;
  logic [15:0]       r_rem;
  logic [1:0]        r_lane;
  logic [31:0]       r_word;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_addr_out;
  logic [3:0]        r_be_out;
  logic [31:0]       r_wdata;
  logic              r_write;
  logic              r_done;
  logic              r_error;
  logic              r_core_reset;
`ifdef LOADER_CSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_acc;
  logic              w_last_pay;
  logic              w_hdr_last_exp;
  logic              w_data_last_exp;
  logic [31:0]       w_word;
  logic [3:0]        w_be;

  assign w_acc      = s_valid & s_ready;
  assign w_last_pay = (r_rem == 16'd1);

  // Which byte is allowed to carry s_last depends on whether a checksum follows
`ifdef LOADER_CSUM_EN
  assign w_hdr_last_exp  = 1'b0;
  assign w_data_last_exp = 1'b0;
`else
  assign w_hdr_last_exp  = (r_hdr_idx == 2'd3) && (r_len == 16'd0);
  assign w_data_last_exp = w_last_pay;
`endif

  always_comb begin
    w_word = r_word;
    w_be   = r_be;
    case (r_lane)
      2'd0:    begin w_word[7:0]   = s_data; w_be[0] = 1'b1; end
      2'd1:    begin w_word[15:8]  = s_data; w_be[1] = 1'b1; end
      2'd2:    begin w_word[23:16] = s_data; w_be[2] = 1'b1; end
      default: begin w_word[31:24] = s_data; w_be[3] = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_live       <= 1'b0;
      r_hdr_idx    <= 2'd0;
      r_len        <= 16'd0;
      r_base_lo    <= 8'd0;
      r_rem        <= 16'd0;
      r_lane       <= 2'd0;
      r_word       <= 32'd0;
      r_be         <= 4'd0;
      r_addr       <= '0;
      r_addr_out   <= '0;
      r_be_out     <= 4'd0;
      r_wdata      <= 32'd0;
      r_write      <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_core_reset <= 1'b1;
`ifdef LOADER_CSUM_EN
      r_csum       <= 8'd0;
`endif
    end else begin
      r_live  <= 1'b1;
      r_write <= 1'b0;
      case (r_state)
        S_IDLE: if (w_acc) begin
          r_len[7:0] <= s_data;
          r_hdr_idx  <= 2'd1;
          if (s_last) begin
            r_state <= S_ERR;
            r_error <= 1'b1;
          end else begin
            r_state <= S_HDR;
          end
        end

        S_HDR: if (w_acc) begin
          r_hdr_idx <= r_hdr_idx + 2'd1;
          if (s_last != w_hdr_last_exp) begin
            r_state <= S_ERR;
            r_error <= 1'b1;
          end else if (r_hdr_idx == 2'd1) begin
            r_len[15:8] <= s_data;
          end else if (r_hdr_idx == 2'd2) begin
            r_base_lo <= s_data;
          end else begin
            r_addr <= ADDR_W'({s_data, r_base_lo});
            r_rem  <= r_len;
            r_lane <= 2'd0;
            r_word <= 32'd0;
            r_be   <= 4'd0;
`ifdef LOADER_CSUM_EN
            r_csum <= 8'd0;
            r_state <= (r_len == 16'd0) ? S_CSUM : S_DATA;
`else
            if (r_len == 16'd0) begin
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_core_reset <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
`endif
          end
        end

        S_DATA: if (w_acc) begin
          if (s_last != w_data_last_exp) begin
            // Pending partial word is dropped: nothing is written after an error
            r_state <= S_ERR;
            r_error <= 1'b1;
          end else begin
            r_rem  <= r_rem - 16'd1;
            r_lane <= r_lane + 2'd1;
            r_word <= w_word;
            r_be   <= w_be;
`ifdef LOADER_CSUM_EN
            r_csum <= r_csum ^ s_data;
`endif
            if ((r_lane == 2'd3) || w_last_pay) begin
              r_write    <= 1'b1;
              r_wdata    <= w_word;
              r_be_out   <= w_be;
              r_addr_out <= r_addr;
              r_addr     <= r_addr + ADDR_W'(1);
              r_word     <= 32'd0;
              r_be       <= 4'd0;
            end
            if (w_last_pay) begin
`ifdef LOADER_CSUM_EN
              r_state <= S_CSUM;
`else
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_core_reset <= 1'b0;
`endif
            end
          end
        end

        S_CSUM: begin
`ifdef LOADER_CSUM_EN
          if (w_acc) begin
            if (s_last && (s_data == r_csum)) begin
              r_state      <= S_DONE;
              r_done       <= 1'b1;
              r_core_reset <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
            end
          end
`else
          r_state <= S_ERR;
          r_error <= 1'b1;
`endif
        end

        S_DONE: if (rearm) begin
          r_state      <= S_IDLE;
          r_done       <= 1'b0;
          r_core_reset <= 1'b1;
        end

        S_ERR: if (rearm) begin
          r_state <= S_IDLE;
          r_error <= 1'b0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_ready        = r_live && (r_state != S_DONE);
  assign address2       = r_addr_out;
  assign byteenable2    = r_be_out;
  assign write2         = r_write;
  assign chipselect2    = r_write;
  assign writedata2     = r_wdata;
  assign clken2         = 1'b1;
  assign core_reset_req = r_core_reset;
  assign done           = r_done;
  assign error          = r_error;

endmodule

// File: tb/tb_multicore_core_image_loader.sv
// Scoreboard bench for multicore_core_image_loader; expected RAM writes are queued as images are driven.
// Follows LOADER_CSUM_EN the same way the design does.
module tb_multicore_core_image_loader;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [7:0]        s_data = 8'd0;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic              rearm = 1'b0;
  logic [ADDR_W-1:0] address2;
  logic [3:0]        byteenable2;
  logic              chipselect2;
  logic              write2;
  logic [31:0]       writedata2;
  logic              clken2;
  logic              core_reset_req;
  logic              done;
  logic              error;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [3:0]        be;
    logic [31:0]       d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  failures = 0;

  multicore_core_image_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .rearm(rearm), .address2(address2), .byteenable2(byteenable2),
    .chipselect2(chipselect2), .write2(write2), .writedata2(writedata2), .clken2(clken2),
    .core_reset_req(core_reset_req), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Write monitor: every RAM write must match the head of the expected queue
  always @(negedge clk) begin
    if (reset_n && write2) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h be=%h data=%h", address2, byteenable2, writedata2);
      end else begin
        mon_e = exp_q.pop_front();
        if ({address2, byteenable2, writedata2} !== {mon_e.a, mon_e.be, mon_e.d}) begin
          failures++;
          $display("FAIL write got addr=%h be=%h data=%h expected addr=%h be=%h data=%h",
                   address2, byteenable2, writedata2, mon_e.a, mon_e.be, mon_e.d);
        end
        checks++;
        if (chipselect2 !== 1'b1) begin
          failures++;
          $display("FAIL chipselect2 got=%b expected=1", chipselect2);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    int t = 0;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    while (!s_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!s_ready) begin
      checks++;
      failures++;
      $display("FAIL s_ready_timeout byte=%h got s_ready=0 expected 1", d);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] len, input logic [15:0] base, input logic last3);
    send_byte(len[7:0], 1'b0);
    send_byte(len[15:8], 1'b0);
    send_byte(base[7:0], 1'b0);
    send_byte(base[15:8], last3);
  endtask

  // Sends n payload bytes starting at first, incrementing; s_last goes on the image's final byte
  task automatic send_incr(input logic [7:0] first, input int n, input logic [7:0] csum);
    for (int k = 0; k < n; k++) begin
`ifdef LOADER_CSUM_EN
      send_byte(first + 8'(k), 1'b0);
`else
      send_byte(first + 8'(k), k == n - 1);
`endif
    end
`ifdef LOADER_CSUM_EN
    send_byte(csum, 1'b1);
`else
    if (csum == 8'hEE) $display("note: unused checksum %h", csum);
`endif
  endtask

  task automatic do_rearm();
    rearm = 1'b1;
    @(posedge clk); #1;
    rearm = 1'b0;
  endtask

  task automatic drain_check(input string name);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_writes_missing got pending=%0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_ready, write2, chipselect2, byteenable2, address2, writedata2, done, error, core_reset_req, clken2}
        !== {1'b0, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL reset_values got rdy=%b wr=%b cs=%b be=%h a=%h d=%h done=%b err=%b crr=%b ck=%b",
               s_ready, write2, chipselect2, byteenable2, address2, writedata2, done, error, core_reset_req, clken2);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL ready_before_edge got=%b expected=0", s_ready); end
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b expected=1", s_ready); end
  endtask

  task automatic test_len8();
    exp_q.push_back('{a: 12'h010, be: 4'hF, d: 32'h14131211});
    exp_q.push_back('{a: 12'h011, be: 4'hF, d: 32'h18171615});
    send_hdr(16'd8, 16'h0010, 1'b0);
    send_incr(8'h11, 8, 8'h08);
    checks++;
    if ({done, error, core_reset_req, s_ready} !== 4'b1000) begin
      failures++;
      $display("FAIL len8_status got done=%b err=%b crr=%b rdy=%b expected 1 0 0 0", done, error, core_reset_req, s_ready);
    end
    drain_check("len8");
    do_rearm();
    checks++;
    if ({done, error, core_reset_req, s_ready} !== 4'b0011) begin
      failures++;
      $display("FAIL len8_rearm got done=%b err=%b crr=%b rdy=%b expected 0 0 1 1", done, error, core_reset_req, s_ready);
    end
  endtask

  task automatic test_wrap();
    exp_q.push_back('{a: 12'hFFF, be: 4'hF, d: 32'hA3A2A1A0});
    exp_q.push_back('{a: 12'h000, be: 4'h1, d: 32'h000000A4});
    send_hdr(16'd5, 16'h0FFF, 1'b0);
    send_incr(8'hA0, 5, 8'hA4);
    checks++;
    if ({done, error, core_reset_req} !== 3'b100) begin
      failures++;
      $display("FAIL wrap_status got done=%b err=%b crr=%b expected 1 0 0", done, error, core_reset_req);
    end
    drain_check("wrap");
    do_rearm();
  endtask

  task automatic test_bad_final();
`ifdef LOADER_CSUM_EN
    exp_q.push_back('{a: 12'h020, be: 4'hF, d: 32'h0C402010});
    send_hdr(16'd4, 16'h0020, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h40, 1'b0);
    send_byte(8'h0C, 1'b0);
    send_byte(8'h00, 1'b1);
`else
    send_hdr(16'd0, 16'h0020, 1'b0);
`endif
    checks++;
    if ({done, error, core_reset_req, s_ready} !== 4'b0111) begin
      failures++;
      $display("FAIL bad_final_status got done=%b err=%b crr=%b rdy=%b expected 0 1 1 1", done, error, core_reset_req, s_ready);
    end
    drain_check("bad_final");
    do_rearm();
    checks++;
    if ({error, core_reset_req, s_ready} !== 3'b011) begin
      failures++;
      $display("FAIL bad_final_rearm got err=%b crr=%b rdy=%b expected 0 1 1", error, core_reset_req, s_ready);
    end
  endtask

  task automatic test_early_last();
    send_hdr(16'd8, 16'h0030, 1'b0);
    send_byte(8'h21, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h23, 1'b1);
    checks++;
    if ({error, done} !== 2'b10) begin
      failures++;
      $display("FAIL early_last_err got err=%b done=%b expected 1 0", error, done);
    end
    for (int k = 0; k < 3; k++) send_byte(8'h30 + 8'(k), 1'b0);
    checks++;
    if ({error, s_ready, core_reset_req} !== 3'b111) begin
      failures++;
      $display("FAIL early_last_drop got err=%b rdy=%b crr=%b expected 1 1 1", error, s_ready, core_reset_req);
    end
    drain_check("early_last");
    do_rearm();
  endtask

  task automatic test_len0();
`ifdef LOADER_CSUM_EN
    send_hdr(16'd0, 16'h0040, 1'b0);
    send_byte(8'h00, 1'b1);
`else
    send_hdr(16'd0, 16'h0040, 1'b1);
`endif
    checks++;
    if ({done, error, core_reset_req} !== 3'b100) begin
      failures++;
      $display("FAIL len0_status got done=%b err=%b crr=%b expected 1 0 0", done, error, core_reset_req);
    end
    drain_check("len0");
    do_rearm();
  endtask

  task automatic test_reset_mid();
    exp_q.push_back('{a: 12'h050, be: 4'hF, d: 32'h04030201});
    send_hdr(16'd8, 16'h0050, 1'b0);
    for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b0);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, write2, chipselect2, byteenable2, address2, writedata2, done, error, core_reset_req}
        !== {1'b0, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL mid_reset_values got rdy=%b wr=%b be=%h a=%h d=%h done=%b err=%b crr=%b",
               s_ready, write2, byteenable2, address2, writedata2, done, error, core_reset_req);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL mid_reset_first_word got pending=%0d expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back('{a: 12'h060, be: 4'hF, d: 32'hC3C2C1C0});
    send_hdr(16'd4, 16'h0060, 1'b0);
    send_incr(8'hC0, 4, 8'h00);
    checks++;
    if ({done, error, core_reset_req} !== 3'b100) begin
      failures++;
      $display("FAIL mid_reset_reload got done=%b err=%b crr=%b expected 1 0 0", done, error, core_reset_req);
    end
    drain_check("mid_reset");
  endtask

  initial begin
    test_reset();
    test_len8();
    test_wrap();
    test_bad_final();
    test_early_last();
    test_len0();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
